// File: rtl/exc_ctrl_if.sv
// Decode-stage, CP0 and fetch-control signals of the exception sequencer.
// master: the sequencer itself; slave: the decode/CP0/fetch side.
interface exc_ctrl_if;
  logic        inst_valid_i;
  logic [2:0]  inst_class_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  cp0_reg_i;
  logic [31:0] gpr_data_i;
  logic [31:0] epc_i;
  logic [31:0] cp0_data_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic [4:0]  cp0_raddr_o;
  logic [1:0]  cp0_type_o;
  logic [31:0] cp0_inst_addr_o;
  logic [31:0] mfc0_data_o;
  logic        mfc0_valid_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    input  inst_valid_i, inst_class_i, inst_addr_i, cp0_reg_i, gpr_data_i, epc_i, cp0_data_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o, cp0_raddr_o, cp0_type_o, cp0_inst_addr_o,
           mfc0_data_o, mfc0_valid_o, stall_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    output inst_valid_i, inst_class_i, inst_addr_i, cp0_reg_i, gpr_data_i, epc_i, cp0_data_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, cp0_raddr_o, cp0_type_o, cp0_inst_addr_o,
           mfc0_data_o, mfc0_valid_o, stall_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception sequencer: decodes syscall/break/eret/mtc0/mfc0, pulses CP0,
// and flushes then redirects fetch to the handler or the saved EPC.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2   // legal range 1..15
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [2:0] C_SYS  = 3'd1;
  localparam logic [2:0] C_BRK  = 3'd2;
  localparam logic [2:0] C_ERET = 3'd3;
  localparam logic [2:0] C_MTC0 = 3'd4;
  localparam logic [2:0] C_MFC0 = 3'd5;

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  exc_q;
  logic [1:0]  type_q;
  logic [31:0] iaddr_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        mfv_q;
  logic [31:0] mfd_q;
  logic [31:0] rpc_q;

  logic        idle, take, take_exc, take_mtc0, take_mfc0;
  logic [1:0]  exc_code;
  logic [31:0] mfc0_fwd;
  logic [31:0] redir_pc;

  assign idle      = (state_q == S_IDLE);
  assign take      = idle && bus.inst_valid_i;
  assign take_mtc0 = take && (bus.inst_class_i == C_MTC0);
  assign take_mfc0 = take && (bus.inst_class_i == C_MFC0);

  always_comb begin
    exc_code = 2'b00;
    case (bus.inst_class_i)
      C_SYS:   exc_code = 2'b01;
      C_BRK:   exc_code = 2'b10;
      C_ERET:  exc_code = 2'b11;
      default: exc_code = 2'b00;
    endcase
  end

  assign take_exc = take && (exc_code != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (take_exc) begin
        state_d = S_FLUSH;
        cnt_d   = FC;
      end
      S_FLUSH: if (cnt_q <= 4'd1) begin
        state_d = S_REDIR;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-after-write: the CP0 write issued last cycle lands only at the end
  // of this one, so a same-register mfc0 takes the in-flight data. Cause
  // (reg 13) only has its software-writable IP[1:0] bits overlaid.
  always_comb begin
    mfc0_fwd = bus.cp0_data_i;
    if (we_q && (bus.cp0_reg_i == waddr_q)) begin
      if (waddr_q == 5'd13)
        mfc0_fwd = {bus.cp0_data_i[31:10], wdata_q[9:8], bus.cp0_data_i[7:0]};
      else
        mfc0_fwd = wdata_q;
    end
  end

  // eret uses EPC as seen during REDIRECT so a just-issued mtc0 to EPC is honoured.
  assign redir_pc = (exc_q == 2'b11) ? bus.epc_i : HANDLER_ADDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      exc_q   <= 2'b00;
      type_q  <= 2'b00;
      iaddr_q <= 32'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      mfv_q   <= 1'b0;
      mfd_q   <= 32'd0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= take_exc ? exc_code : 2'b00;
      if (take_exc) begin
        exc_q   <= exc_code;
        iaddr_q <= bus.inst_addr_i;
      end
      we_q <= take_mtc0;
      if (take_mtc0) begin
        waddr_q <= bus.cp0_reg_i;
        wdata_q <= bus.gpr_data_i;
      end
      mfv_q <= take_mfc0;
      if (take_mfc0) mfd_q <= mfc0_fwd;
      if (state_q == S_REDIR) rpc_q <= redir_pc;
    end
  end

  assign bus.cp0_we_o        = we_q;
  assign bus.cp0_waddr_o     = waddr_q;
  assign bus.cp0_wdata_o     = wdata_q;
  assign bus.cp0_raddr_o     = bus.cp0_reg_i;
  assign bus.cp0_type_o      = type_q;
  assign bus.cp0_inst_addr_o = iaddr_q;
  assign bus.mfc0_data_o     = mfd_q;
  assign bus.mfc0_valid_o    = mfv_q;
  assign bus.flush_o         = (state_q == S_FLUSH);
  assign bus.stall_o         = (state_q == S_FLUSH) || (state_q == S_REDIR);
  assign bus.redirect_o      = (state_q == S_REDIR);
  assign bus.redirect_pc_o   = (state_q == S_REDIR) ? redir_pc : rpc_q;
  assign bus.busy_o          = !idle;
endmodule
